// File: rtl/cpu_pkg.sv
// Shared widths and the operand-fetch state enumeration for the issue pipeline.
package cpu_pkg;
    localparam int BITS_DATA = 32;
    localparam int BITS_ADDR = 3;
    localparam int NUM_REGS  = 8;
    localparam int BITS_OP   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/reg_scoreboard.sv
// One pending-write bit per register; a set and a clear of the same bit in one
// cycle leaves the bit set.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int BITS_ADDR = cpu_pkg::BITS_ADDR,
    parameter int NUM_REGS  = 2 ** BITS_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [BITS_ADDR-1:0] set_addr,
    input  logic                 clr_en,
    input  logic [BITS_ADDR-1:0] clr_addr,
    output logic [NUM_REGS-1:0]  bits
);
    logic [NUM_REGS-1:0] bits_d, bits_q;

    always_comb begin
        bits_d = bits_q;
        if (clr_en) bits_d[clr_addr] = 1'b0;
        if (set_en) bits_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bits_q <= '0;
        else        bits_q <= bits_d;
    end

    assign bits = bits_q;
endmodule

// File: rtl/operand_fetch.sv
// Holds one instruction, waits out register hazards tracked by the scoreboard,
// then presents its operands on a valid/ready output until taken.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int BITS_DATA = cpu_pkg::BITS_DATA,
    parameter int BITS_ADDR = cpu_pkg::BITS_ADDR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [BITS_ADDR-1:0]          instr_rs1,
    input  logic [BITS_ADDR-1:0]          instr_rs2,
    input  logic [BITS_ADDR-1:0]          instr_rd,
    input  logic [BITS_OP-1:0]            instr_op,
    input  logic                          instr_wb,
    output logic [BITS_ADDR-1:0]          rf_raddr1,
    output logic [BITS_ADDR-1:0]          rf_raddr2,
    input  logic [BITS_DATA-1:0]          rf_rdata1,
    input  logic [BITS_DATA-1:0]          rf_rdata2,
    input  logic                          wb_valid,
    input  logic [BITS_ADDR-1:0]          wb_addr,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [BITS_DATA-1:0]          op_a,
    output logic [BITS_DATA-1:0]          op_b,
    output logic [BITS_ADDR-1:0]          op_rd,
    output logic [BITS_OP-1:0]            op_op,
    output logic                          op_wb,
    output logic [15:0]                   stall_count,
    output fetch_state_e                  dbg_state,
    output logic [(2**BITS_ADDR)-1:0]     dbg_scoreboard
);
    localparam int NREGS = 2 ** BITS_ADDR;
    localparam logic [NREGS-1:0] ONE_HOT0 = NREGS'(1);

    fetch_state_e         state_d, state_q;
    logic                 alive_d, alive_q;
    logic [BITS_ADDR-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [BITS_OP-1:0]   opc_d, opc_q;
    logic                 wb_d, wb_q;
    logic [BITS_DATA-1:0] op_a_d, op_a_q, op_b_d, op_b_q;
    logic [BITS_ADDR-1:0] op_rd_d, op_rd_q;
    logic [BITS_OP-1:0]   op_op_d, op_op_q;
    logic                 op_wb_d, op_wb_q;
    logic [15:0]          stall_d, stall_q;
    logic                 sb_set;
    logic [NREGS-1:0]     sb_bits, clr_mask, sb_eff;
    logic                 hazard;

    reg_scoreboard #(.BITS_ADDR(BITS_ADDR), .NUM_REGS(NREGS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_addr (rd_q),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .bits     (sb_bits)
    );

    // A writeback landing this cycle already resolves the hazard it clears.
    assign clr_mask = wb_valid ? (ONE_HOT0 << wb_addr) : '0;
    assign sb_eff   = sb_bits & ~clr_mask;
    assign hazard   = sb_eff[rs1_q] | sb_eff[rs2_q] | (wb_q & sb_eff[rd_q]);

    // alive_q keeps instr_ready low until the first edge after reset release.
    assign instr_ready = alive_q && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        alive_d = 1'b1;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        opc_d   = opc_q;
        wb_d    = wb_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_rd_d = op_rd_q;
        op_op_d = op_op_q;
        op_wb_d = op_wb_q;
        stall_d = stall_q;
        sb_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_ready && instr_valid) begin
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    rd_d    = instr_rd;
                    opc_d   = instr_op;
                    wb_d    = instr_wb;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hazard) begin
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else begin
                    op_a_d  = rf_rdata1;
                    op_b_d  = rf_rdata2;
                    op_rd_d = rd_q;
                    op_op_d = opc_q;
                    op_wb_d = wb_q;
                    sb_set  = wb_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (op_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            opc_q   <= '0;
            wb_q    <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_rd_q <= '0;
            op_op_q <= '0;
            op_wb_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            opc_q   <= opc_d;
            wb_q    <= wb_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_rd_q <= op_rd_d;
            op_op_q <= op_op_d;
            op_wb_q <= op_wb_d;
            stall_q <= stall_d;
        end
    end

    assign rf_raddr1      = rs1_q;
    assign rf_raddr2      = rs2_q;
    assign op_valid       = (state_q == ISSUE);
    assign op_a           = op_a_q;
    assign op_b           = op_b_q;
    assign op_rd          = op_rd_q;
    assign op_op          = op_op_q;
    assign op_wb          = op_wb_q;
    assign stall_count    = stall_q;
    assign dbg_state      = state_q;
    assign dbg_scoreboard = sb_bits;
endmodule
